// File: rtl/brom_pkg.sv
// Shared definitions for the boot-ROM loader: FSM state encoding and ROM depth.
package brom_pkg;

    localparam int BROM_ADDR_W = 8;

    function automatic int brom_depth(input int aw);
        return 1 << aw;
    endfunction

    localparam int BROM_DEPTH = brom_depth(BROM_ADDR_W);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } brom_state_e;

endpackage

// File: rtl/brom_loader_if.sv
// Host byte stream and CPU boot-ROM read bus of the boot-ROM loader.
interface brom_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;

    // master: host stream source plus CPU read side; slave: the loader
    modport master (
        output wr_data,
        output wr_valid,
        input  wr_ready,
        output a,
        input  d
    );

    modport slave (
        input  wr_data,
        input  wr_valid,
        output wr_ready,
        input  a,
        output d
    );
endinterface

// File: rtl/brom_ram.sv
// Boot-ROM image storage: one synchronous write port, one asynchronous read port.
module brom_ram
    import brom_pkg::*;
#(
    parameter int ADDR_W = BROM_ADDR_W
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [7:0]        wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [7:0]        rd_data_o
);
    localparam int DEPTH = brom_depth(ADDR_W);

    // contents deliberately survive reset so a partial image stays readable
    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/brom_loader.sv
// Boot-ROM loader: streams an image into brom_ram and holds the CPU until done.
// Define BROM_LOADER_CHECKSUM_EN to require a trailing checksum byte after the image.
module brom_loader
    import brom_pkg::*;
#(
    parameter int ADDR_W = BROM_ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    brom_loader_if.slave  bus,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          cpu_hold
);
    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

    brom_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [7:0]        acc_q, acc_d;
    logic              ram_we;
    logic              ready_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ram_we  = 1'b0;
        ready_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            LOAD: begin
                // start is not looked at here, so it cannot disturb a load
                ready_c = 1'b1;
                if (bus.wr_valid) begin
                    ram_we = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    acc_d  = acc_q + bus.wr_data;
                    if (cnt_q == CNT_LAST) begin
`ifdef BROM_LOADER_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
            CHECK: begin
`ifdef BROM_LOADER_CHECKSUM_EN
                ready_c = 1'b1;
                if (bus.wr_valid) begin
                    acc_d   = acc_q + bus.wr_data;
                    state_d = (acc_d == 8'h00) ? DONE : ERROR;
                end
`else
                state_d = IDLE;
`endif
            end
            DONE, ERROR: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.wr_ready = ready_c;
    assign busy         = (state_q == LOAD) || (state_q == CHECK);
    assign done         = (state_q == DONE);
    assign cpu_hold     = (state_q != DONE);
`ifdef BROM_LOADER_CHECKSUM_EN
    assign error        = (state_q == ERROR);
`else
    assign error        = 1'b0;
`endif

    brom_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .we_i      (ram_we),
        .wr_addr_i (cnt_q),
        .wr_data_i (bus.wr_data),
        .rd_addr_i (bus.a),
        .rd_data_o (bus.d)
    );

endmodule

// File: tb/tb_brom_loader.sv
// Directed self-checking bench for brom_loader; follows BROM_LOADER_CHECKSUM_EN.
module tb_brom_loader;
    import brom_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic busy, done, error, cpu_hold;

    brom_loader_if #(.ADDR_W(8)) bus ();

    brom_loader #(.ADDR_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cpu_hold (cpu_hold)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int err_seen = 0;
    logic [7:0] exp_mem [BROM_DEPTH];

    always @(negedge clk) if (error === 1'b1) err_seen++;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gen(input int mode, input int i);
        logic [7:0] v;
        v = 8'(i);
        case (mode)
            1:       return 8'(i * 7 + 3);
            2:       return v ^ 8'hA5;
            default: return v;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic with_start);
        bit ok;
        ok = 0;
        bus.wr_data  = b;
        bus.wr_valid = 1'b1;
        start        = with_start;
        for (int k = 0; k < 8 && !ok; k++) begin
            @(negedge clk);
            if (bus.wr_ready === 1'b1) ok = 1;
            step();
            start = 1'b0;
        end
        bus.wr_valid = 1'b0;
        start        = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL push_timeout byte=%02h wr_ready=%b required=1", b, bus.wr_ready);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic load_image(input int mode, input bit gaps, input bit corrupt);
        logic [7:0] sum, b;
        sum = 8'h00;
        for (int i = 0; i < BROM_DEPTH; i++) begin
            b = gen(mode, i);
            exp_mem[i] = b;
            sum = sum + b;
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) begin
                    start = (g == 2);
                    step();
                    start = 1'b0;
                end
            end
            push_byte(b, gaps && (i % 17 == 5));
        end
`ifdef BROM_LOADER_CHECKSUM_EN
        push_byte(8'h00 - sum + 8'(corrupt), 1'b0);
`endif
        $display("load mode=%0d gaps=%0d corrupt=%0d sum=%02h", mode, gaps, corrupt, sum);
    endtask

    task automatic test_reset();
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        bus.a        = 8'h00;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (10) step();
        @(negedge clk);
        checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL reset_cpu_hold got=%b exp=1", cpu_hold); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL reset_wr_ready got=%b exp=0", bus.wr_ready); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", error); end
        $display("test_reset complete");
        step();
    endtask

    task automatic test_good_load();
        pulse_start();
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL load_busy got=%b exp=1", busy); end
        checks++; if (bus.wr_ready !== 1'b1) begin failures++; $display("FAIL load_wr_ready got=%b exp=1", bus.wr_ready); end
        step();
        load_image(0, 0, 0);
        @(negedge clk);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL good_done got=%b exp=1", done); end
        checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL good_cpu_hold got=%b exp=0", cpu_hold); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL good_busy got=%b exp=0", busy); end
        checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL good_wr_ready got=%b exp=0", bus.wr_ready); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL good_error got=%b exp=0", error); end
        for (int i = 0; i < BROM_DEPTH; i++) begin
            bus.a = 8'(i);
            #1;
            checks++;
            if (bus.d !== 8'(i)) begin failures++; $display("FAIL good_rd a=%02h got=%02h exp=%02h", i, bus.d, 8'(i)); end
        end
        $display("test_good_load complete");
        step();
    endtask

    task automatic test_checksum_and_reload();
`ifdef BROM_LOADER_CHECKSUM_EN
        pulse_start();
        load_image(0, 0, 1);
        @(negedge clk);
        checks++; if (error !== 1'b1) begin failures++; $display("FAIL bad_error got=%b exp=1", error); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL bad_done got=%b exp=0", done); end
        checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL bad_cpu_hold got=%b exp=1", cpu_hold); end
        step();
`endif
        pulse_start();
        @(negedge clk);
        checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL restart_cpu_hold got=%b exp=1", cpu_hold); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL restart_done got=%b exp=0", done); end
        step();
        load_image(1, 0, 0);
        @(negedge clk);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL reload_done got=%b exp=1", done); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL reload_error got=%b exp=0", error); end
        $display("test_checksum_and_reload complete");
        step();
    endtask

    task automatic test_gaps_start();
        pulse_start();
        load_image(1, 1, 0);
        @(negedge clk);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL gaps_done got=%b exp=1", done); end
        for (int i = 0; i < BROM_DEPTH; i++) begin
            bus.a = 8'(i);
            #1;
            checks++;
            if (bus.d !== exp_mem[i]) begin failures++; $display("FAIL gaps_rd a=%02h got=%02h exp=%02h", i, bus.d, exp_mem[i]); end
        end
        $display("test_gaps_start complete");
        step();
    endtask

    task automatic test_reset_midload();
        logic [7:0] b, sum, last;
        pulse_start();
        for (int i = 0; i <= 8'h37; i++) begin
            b = gen(2, i);
            exp_mem[i] = b;
            push_byte(b, 1'b0);
        end
        bus.wr_data  = 8'hEE;
        bus.wr_valid = 1'b1;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL midrst_wr_ready got=%b exp=0", bus.wr_ready); end
        repeat (3) step();
        rst = 1'b0;
        bus.wr_valid = 1'b0;
        step();
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
        checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL midrst_cpu_hold got=%b exp=1", cpu_hold); end
        for (int i = 8'h36; i <= 8'h39; i++) begin
            bus.a = 8'(i);
            #1;
            checks++;
            if (bus.d !== exp_mem[i]) begin failures++; $display("FAIL midrst_rd a=%02h got=%02h exp=%02h", i, bus.d, exp_mem[i]); end
        end
        step();
        pulse_start();
        sum  = 8'h00;
        last = 8'h00;
        for (int i = 0; i < BROM_DEPTH; i++) begin
            b = gen(2, i);
            exp_mem[i] = b;
            sum = sum + b;
`ifdef BROM_LOADER_CHECKSUM_EN
            push_byte(b, 1'b0);
            last = 8'h00 - sum;
`else
            if (i < BROM_DEPTH - 1) push_byte(b, 1'b0);
            else last = b;
`endif
        end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL early_done got=%b exp=0", done); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL early_busy got=%b exp=1", busy); end
        step();
        push_byte(last, 1'b0);
        @(negedge clk);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL reload_final_done got=%b exp=1", done); end
        for (int i = 0; i < BROM_DEPTH; i++) begin
            bus.a = 8'(i);
            #1;
            checks++;
            if (bus.d !== exp_mem[i]) begin failures++; $display("FAIL reload_rd a=%02h got=%02h exp=%02h", i, bus.d, exp_mem[i]); end
        end
        $display("test_reset_midload complete");
        step();
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        bus.a        = 8'h00;
        test_reset();
        test_good_load();
        test_checksum_and_reload();
        test_gaps_start();
        test_reset_midload();
`ifndef BROM_LOADER_CHECKSUM_EN
        checks++;
        if (err_seen != 0) begin failures++; $display("FAIL error_asserted got=%0d exp=0", err_seen); end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
